arithmetic: RTL and testbench
=============================

// Module: arithmetic
// PURPOSE
//  PS/2 mouse movement-magnitude unit. Takes one signed X/Y movement pair from the
//  packet decoder and returns z = floor(sqrt(|x|^2 + |y|^2)).
//  Sequential, one operation in flight, valid/ready in and single-cycle valid pulse out.
//  Sits between the PS/2 packet decoder and the display/readout logic.
// PARAMETERS
//  IN_W   9   width of each axis input: 1 sign bit plus 8 data bits, two's complement
//  OUT_W  9   width of z_axis; also the number of square-root iterations (ceil(17/2) = 9)
// PORTS
//  clk        in   1      single system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      x_axis/y_axis valid; accepted only when in_ready=1
//  in_ready   out  1      high in IDLE
//  x_axis     in   IN_W   X movement, two's complement
//  y_axis     in   IN_W   Y movement, two's complement
//  z_axis     out  OUT_W  result magnitude; holds the last result until the next result
//  out_valid  out  1      one-cycle pulse when z_axis has just been updated
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, z_axis=0, out_valid=0, in_ready=1, internals 0.
//  - Magnitude rules:
//    - sign=0: |v| = v[7:0].
//    - sign=1: |v| = (~v[7:0] + 1) mod 256.
//    - v = -256 (9'h100) saturates to 255.
//  - Radicand R = |x|*|x| + |y|*|y|: 17-bit unsigned, max 130050.
//  - Root: non-restoring integer square root, 1 result bit per clock, MSB first,
//    OUT_W iterations. Result = floor(sqrt(R)); max 360, fits 9 bits.
//  - FSM:
//    - IDLE: in_ready=1. in_valid=1 latches the magnitudes -> SQUARE.
//    - SQUARE: register R, clear root/remainder -> ROOT.
//    - ROOT: OUT_W iterations, then -> DONE.
//    - DONE: load z_axis, out_valid=1 for this cycle only -> IDLE.
//  - Latency: out_valid is high in the cycle after the 11th rising edge that follows the
//    accepting edge. Throughput: one result per 12 cycles.
//  - in_valid outside IDLE is ignored; inputs are not re-sampled. No input buffering.
//  - in_valid held high in the DONE cycle is not accepted. It is accepted on the next
//    IDLE edge, with in_ready high again.
//  - Reset mid-operation aborts the operation: nothing is emitted, z_axis=0.
//  - No overflow is possible at the chosen widths. Multipliers are 8x8 -> 16 bits.
//    The remainder register is 11 bits, signed.
// STRUCTURE
//  - Package arithmetic_pkg: IN_W/OUT_W defaults, RAD_W=17, state enum {IDLE,SQUARE,ROOT,DONE}.
//  - Package also holds the abs-magnitude function with -256 saturation.
//  - Sub-module isqrt_iter: start/done handshake, R input, OUT_W-bit root output.
//    It holds the iteration counter, partial root and signed remainder.
//  - Top: input capture, magnitude, squaring, FSM, output register.
// TESTING
//  - x=9'd3, y=9'd4, in_valid 1 cycle -> out_valid pulse after the latency above, z=5.
//  - x=9'h1FD (-3), y=9'h1FC (-4) -> z=5.
//  - x=9'd255, y=9'd255 -> z=360.
//  - x=0, y=0 -> z=0.
//  - x=9'h100 (-256), y=0 -> z=255.
//  - Busy and reset cases:
//    - in_valid held high continuously -> results exactly 12 cycles apart.
//    - New inputs while busy are ignored.
//    - rst_n pulsed mid-ROOT -> no out_valid, z_axis=0, in_ready=1.
//  - Randomized 9-bit x/y, 511 operations -> z matches floor(sqrt(|x|^2+|y|^2))
//    with the saturation rule.

Source files
------------

// File: rtl/arithmetic_pkg.sv
// Shared widths, FSM states and the saturating axis-magnitude helper for the mouse magnitude unit.
// No logic of its own: no latency and no backpressure.
package arithmetic_pkg;

  localparam int DEF_IN_W  = 9;
  localparam int DEF_OUT_W = 9;
  localparam int MAG_W     = 8;
  localparam int RAD_W     = 17;
  // Root plus two guard bits, so |remainder| <= 2*root+1 always fits.
  localparam int REM_W     = DEF_OUT_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    ROOT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // -256 has no 8-bit magnitude, so it clamps to 255.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [DEF_IN_W-1:0] v);
    logic [MAG_W-1:0] neg;
    neg = ~v[MAG_W-1:0] + 1'b1;
    if (!v[DEF_IN_W-1])
      return v[MAG_W-1:0];
    else if (v[MAG_W-1:0] == '0)
      return '1;
    else
      return neg;
  endfunction

endpackage

// File: rtl/arithmetic_isqrt.sv
// Non-restoring integer square root, one root bit per clock, MSB first.
// Latency: OUT_W cycles after start; done marks the last iteration; start is only pulsed when idle.
module isqrt_iter
  import arithmetic_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [RAD_W-1:0] radicand,
  output logic             done,
  output logic [OUT_W-1:0] root
);

  localparam int SH_W  = 2 * OUT_W;
  localparam int CNT_W = $clog2(OUT_W);

  logic [SH_W-1:0]  rad_sh;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  // Bring down the next radicand pair, then add or subtract the trial
  // divisor depending on the sign left by the previous step.
  always_comb begin
    rem_sh = '0;
    trial  = '0;
    rem_sh = {rem[REM_W-3:0], rad_sh[SH_W-1 -: 2]};
    if (rem[REM_W-1])
      trial = rem_sh + {root, 2'b11};
    else
      trial = rem_sh - {root, 2'b01};
  end

  assign done = busy && (cnt == CNT_W'(OUT_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_sh <= '0;
      rem    <= '0;
      root   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      rad_sh <= {{(SH_W - RAD_W){1'b0}}, radicand};
      rem    <= '0;
      root   <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      rad_sh <= {rad_sh[SH_W-3:0], 2'b00};
      rem    <= trial;
      root   <= {root[OUT_W-2:0], ~trial[REM_W-1]};
      cnt    <= cnt + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/arithmetic.sv
// Mouse movement magnitude z = floor(sqrt(|x|^2 + |y|^2)), one operation in flight.
// Latency 11 edges after accept, one result per 12 cycles; in_ready low while busy, no input buffering.
module arithmetic
  import arithmetic_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x_axis,
  input  logic [IN_W-1:0]  y_axis,
  output logic [OUT_W-1:0] z_axis,
  output logic             out_valid
);

  state_t             state;
  logic [MAG_W-1:0]   x_mag;
  logic [MAG_W-1:0]   y_mag;
  logic [2*MAG_W-1:0] x_sq;
  logic [2*MAG_W-1:0] y_sq;
  logic [RAD_W-1:0]   radicand;
  logic               iter_start;
  logic               iter_done;
  logic [OUT_W-1:0]   iter_root;

  assign x_sq       = x_mag * x_mag;
  assign y_sq       = y_mag * y_mag;
  assign radicand   = RAD_W'(x_sq) + RAD_W'(y_sq);
  // The iterator registers the radicand and clears its root/remainder here.
  assign iter_start = (state == SQUARE);

  isqrt_iter #(
    .OUT_W (OUT_W)
  ) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (iter_start),
    .radicand (radicand),
    .done     (iter_done),
    .root     (iter_root)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_mag     <= '0;
      y_mag     <= '0;
      z_axis    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_mag    <= abs_mag(x_axis);
            y_mag    <= abs_mag(y_axis);
            in_ready <= 1'b0;
            state    <= SQUARE;
          end
        end
        SQUARE: state <= ROOT;
        ROOT: begin
          if (iter_done)
            state <= DONE;
        end
        DONE: begin
          z_axis    <= iter_root;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arithmetic.sv
// Directed and randomized checks of the magnitude unit against a plain-arithmetic model.
module tb_arithmetic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] x_axis;
  logic [8:0] y_axis;
  logic [8:0] z_axis;
  logic       out_valid;

  int passed = 0;
  int total  = 0;

  arithmetic dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_axis    (x_axis),
    .y_axis    (y_axis),
    .z_axis    (z_axis),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic int model_mag(input logic [8:0] v);
    int s;
    s = $signed(v);
    if (s == -256) return 255;
    return (s < 0) ? -s : s;
  endfunction

  function automatic int model_sqrt(input int r);
    int z;
    z = 0;
    while ((z + 1) * (z + 1) <= r) z++;
    return z;
  endfunction

  function automatic int model_z(input logic [8:0] x, input logic [8:0] y);
    int mx, my;
    mx = model_mag(x);
    my = model_mag(y);
    return model_sqrt(mx * mx + my * my);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One accepted transaction; returns edges from accept to out_valid (-1 on timeout).
  task automatic run_op(input logic [8:0] x, input logic [8:0] y,
                        output int lat, output int z);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    x_axis   = x;
    y_axis   = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    z = z_axis;
    @(posedge clk);
    #1 chk("pulse_width", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat, z, seen, k0;
    int stamps[$];
    logic [8:0] rx, ry;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    x_axis   = '0;
    y_axis   = '0;
    repeat (2) @(negedge clk);
    chk("rst_z", z_axis, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    run_op(9'd3, 9'd4, lat, z);
    chk("lat_3_4", lat, 11);
    chk("z_3_4", z, 5);
    run_op(9'h1FD, 9'h1FC, lat, z);
    chk("lat_neg", lat, 11);
    chk("z_neg", z, 5);
    run_op(9'd255, 9'd255, lat, z);
    chk("z_max", z, 360);
    run_op(9'd0, 9'd0, lat, z);
    chk("z_zero", z, 0);
    run_op(9'h100, 9'd0, lat, z);
    chk("z_sat", z, 255);
    run_op(9'd0, 9'h100, lat, z);
    chk("z_sat_y", z, 255);

    // in_valid held high: results every 12 cycles, DONE cycle not accepted.
    @(negedge clk);
    x_axis   = 9'd3;
    y_axis   = 9'd4;
    in_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        stamps.push_back(k);
        chk("z_stream", z_axis, 5);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("stream_count", stamps.size(), 3);
    if (stamps.size() >= 3) begin
      chk("stream_first", stamps[0], 12);
      chk("stream_gap1", stamps[1] - stamps[0], 12);
      chk("stream_gap2", stamps[2] - stamps[1], 12);
    end
    repeat (15) @(negedge clk);

    // New inputs while busy are ignored.
    @(negedge clk);
    x_axis   = 9'd3;
    y_axis   = 9'd4;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    x_axis   = 9'd255;
    y_axis   = 9'd255;
    in_valid = 1'b1;
    chk("busy_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    k0   = -1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen++;
        if (k0 < 0) k0 = z_axis;
      end
    end
    chk("busy_results", seen, 1);
    chk("busy_z", k0, 5);

    // Reset in the middle of ROOT aborts the operation.
    @(negedge clk);
    x_axis   = 9'd255;
    y_axis   = 9'd255;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_z", z_axis, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    chk("abort_z_held", z_axis, 0);

    for (int i = 0; i < 511; i++) begin
      rx = 9'($urandom_range(0, 511));
      ry = 9'($urandom_range(0, 511));
      run_op(rx, ry, lat, z);
      chk("rand_lat", lat, 11);
      chk("rand_z", z, model_z(rx, ry));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
